// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the execute2
// stage (priority) and a debug/display port, with a starvation guard that
// force-grants a waiting debug request for one stalled cycle.
module dm_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic              sysclk,
    input  logic              cpu_reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wren,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wren,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       dbg_grants
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DBG  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;

    // State, wait counter and debug-side result registers.
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
            dbg_grants <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            dbg_ack  <= (state == S_DBG);
            if (state == S_DBG) begin
                dbg_rdata  <= mem_rdata;
                dbg_grants <= dbg_grants + 16'd1;
            end
        end
    end

    // Next-state: CPU wins contention until the debug request has waited MAX_WAIT cycles.
    always_comb begin
        state_next = S_IDLE;
        wait_next  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (dbg_req && !cpu_req) begin
                    state_next = S_DBG;
                    wait_next  = '0;
                end else if (dbg_req && cpu_req) begin
                    if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        state_next = S_DBG;
                        wait_next  = '0;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    wait_next = '0;
                end
            end
            S_DBG:   state_next = S_ACK;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Port mux; reset suppresses every write, including one mid debug access.
    always_comb begin
        cpu_rdata = mem_rdata;
        cpu_stall = (state == S_DBG) && cpu_req;
        if (state == S_DBG) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wren  = dbg_we ? 4'hF : 4'h0;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wren  = cpu_req ? cpu_wren : 4'h0;
        end
        if (cpu_reset) begin
            mem_wren = 4'h0;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed stimulus with a cycle-level reference model
// of the arbiter and a shadow copy of data memory.
module tb_dm_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 8;

    logic              sysclk = 1'b0;
    logic              cpu_reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [3:0]        cpu_wren = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wren;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [15:0]       dbg_grants;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .sysclk(sysclk), .cpu_reset(cpu_reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_grants(dbg_grants)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [31:0] init_word(input int unsigned i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Environment data memory: byte-lane writes at the edge, combinational read.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge sysclk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wren[b] === 1'b1) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: which cycle is a debug access / ack, plus shadow memory.
    bit          m_valid = 0;
    bit          m_access, m_ack;
    int unsigned m_waited;
    logic [15:0] m_grants;
    logic [31:0] m_rdata;
    logic [31:0] shadow [256];

    always @(posedge sysclk) begin : model
        bit idle, go;
        if (cpu_reset) begin
            m_valid = 1; m_access = 0; m_ack = 0; m_waited = 0;
            m_grants = 0; m_rdata = 0;
        end else if (m_valid) begin
            if (m_access) begin
                m_rdata = shadow[dbg_addr];
                if (dbg_we) shadow[dbg_addr] = dbg_wdata;
                m_grants = m_grants + 16'd1;
            end else if (cpu_req) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_wren[b]) shadow[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
            end
            idle = !m_access && !m_ack;
            go   = idle && dbg_req && (!cpu_req || m_waited == MAX_WAIT - 1);
            if (idle && dbg_req && cpu_req && !go) m_waited = m_waited + 1;
            else m_waited = 0;
            m_ack    = m_access;
            m_access = go;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge sysclk) begin
        logic [ADDR_W-1:0] ea;
        logic [3:0]        ew;
        if (m_valid) begin
            ea = m_access ? dbg_addr : cpu_addr;
            ew = cpu_reset ? 4'h0 : m_access ? (dbg_we ? 4'hF : 4'h0) : (cpu_req ? cpu_wren : 4'h0);
            chk("mem_addr", 32'(mem_addr), 32'(ea));
            chk("mem_wren", 32'(mem_wren), 32'(ew));
            if (ew != 4'h0) chk("mem_wdata", mem_wdata, m_access ? dbg_wdata : cpu_wdata);
            chk("cpu_rdata", cpu_rdata, shadow[ea]);
            chk("cpu_stall", 32'(cpu_stall), 32'(m_access && cpu_req));
            chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
            chk("dbg_rdata", dbg_rdata, m_rdata);
            chk("dbg_grants", 32'(dbg_grants), 32'(m_grants));
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge sysclk);
    endtask

    initial begin
        int unsigned ack_cyc [$];
        for (int unsigned i = 0; i < 256; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end

        // Reset
        step(); step();
        cpu_reset = 1'b0;
        at_neg();
        chk("rst_ack", 32'(dbg_ack), 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_grants", 32'(dbg_grants), 32'h0);

        // CPU store then load of 0x85
        step();
        cpu_req = 1; cpu_addr = 8'h85; cpu_wren = 4'hF; cpu_wdata = 32'h00000315;
        step();
        cpu_wren = 4'h0;
        at_neg();
        chk("cpu_load_85", cpu_rdata, 32'h00000315);
        chk("cpu_no_stall", 32'(cpu_stall), 32'h0);

        // Uncontended debug read
        step();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 8'h85;
        at_neg();
        chk("unc_n_ack", 32'(dbg_ack), 32'h0);
        step();
        at_neg();
        chk("unc_n1_addr", 32'(mem_addr), 32'h85);
        chk("unc_n1_ack", 32'(dbg_ack), 32'h0);
        step();
        dbg_req = 0;
        at_neg();
        chk("unc_n2_ack", 32'(dbg_ack), 32'h1);
        chk("unc_rdata", dbg_rdata, 32'h00000315);
        chk("unc_grants", 32'(dbg_grants), 32'h1);
        step();
        at_neg();
        chk("unc_n3_ack", 32'(dbg_ack), 32'h0);

        // Starvation: CPU loads every cycle, debug forced in at cycle 8
        step();
        cpu_req = 1; cpu_addr = 8'h10; cpu_wren = 4'h0;
        dbg_req = 1; dbg_addr = 8'h85; dbg_we = 0;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk($sformatf("starve_c%0d_stall", k), 32'(cpu_stall), 32'h0);
            step();
        end
        at_neg();
        chk("starve_c8_stall", 32'(cpu_stall), 32'h1);
        chk("starve_c8_addr", 32'(mem_addr), 32'h85);
        step();
        dbg_req = 0;
        at_neg();
        chk("starve_c9_ack", 32'(dbg_ack), 32'h1);
        chk("starve_c9_stall", 32'(cpu_stall), 32'h0);
        chk("starve_grants", 32'(dbg_grants), 32'h2);

        // Debug write of 987 to 0x90, then CPU load
        step();
        cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 8'h90; dbg_wdata = 32'd987;
        at_neg();
        chk("dwr_n_wren", 32'(mem_wren), 32'h0);
        step();
        at_neg();
        chk("dwr_n1_wren", 32'(mem_wren), 32'hF);
        step();
        dbg_req = 0; dbg_we = 0;
        at_neg();
        chk("dwr_n2_wren", 32'(mem_wren), 32'h0);
        chk("dwr_ack", 32'(dbg_ack), 32'h1);
        step();
        cpu_req = 1; cpu_addr = 8'h90;
        at_neg();
        chk("dwr_cpu_load", cpu_rdata, 32'd987);

        // Reset during the access cycle of a debug write to 0x40
        step();
        cpu_addr = 8'h40; cpu_wren = 4'hF; cpu_wdata = 32'h1;
        step();
        cpu_req = 0; cpu_wren = 4'h0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 32'hDEADBEEF;
        step();
        cpu_reset = 1;
        at_neg();
        chk("rstmid_wren", 32'(mem_wren), 32'h0);
        step();
        cpu_reset = 0; dbg_req = 0; dbg_we = 0;
        cpu_req = 1; cpu_addr = 8'h40;
        at_neg();
        chk("rstmid_ack", 32'(dbg_ack), 32'h0);
        chk("rstmid_grants", 32'(dbg_grants), 32'h0);
        chk("rstmid_word", cpu_rdata, 32'h1);
        chk("rstmid_idle", 32'(cpu_stall), 32'h0);

        // dbg_req held high through ack: back-to-back accesses
        step();
        cpu_req = 0; dbg_req = 1; dbg_addr = 8'h85;
        for (int unsigned c = 0; c < 6; c++) begin
            at_neg();
            if (dbg_ack === 1'b1) ack_cyc.push_back(c);
            step();
        end
        dbg_req = 0;
        chk("held_acks", ack_cyc.size(), 32'd2);
        if (ack_cyc.size() == 2) chk("held_gap", ack_cyc[1] - ack_cyc[0], 32'd3);
        at_neg();
        chk("held_grants", 32'(dbg_grants), 32'h2);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
